// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU operand-issue stage and the ALU it feeds:
// ALUop encodings, MIPS R-type funct codes, halt causes and funct decode.
package alu_issue_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // ALUop encodings understood by the downstream ALU
  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  // MIPS funct field values accepted by the stage
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // halt_cause encodings
  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_OVF     = 2'b01;
  localparam logic [1:0] HALT_ILLEGAL = 2'b10;

  typedef struct packed {
    logic       legal;    // funct is one of the supported operations
    logic       checked;  // signed overflow of this op must trap
    logic [2:0] aluop;
  } decode_t;

  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d = '{legal: 1'b1, checked: 1'b0, aluop: ALUOP_AND};
    case (funct)
      FUNCT_ADD:  begin d.aluop = ALUOP_ADD; d.checked = 1'b1; end
      FUNCT_ADDU: d.aluop = ALUOP_ADD;
      FUNCT_SUB:  begin d.aluop = ALUOP_SUB; d.checked = 1'b1; end
      FUNCT_SUBU: d.aluop = ALUOP_SUB;
      FUNCT_AND:  d.aluop = ALUOP_AND;
      FUNCT_OR:   d.aluop = ALUOP_OR;
      FUNCT_SLT:  d.aluop = ALUOP_SLT;
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_reg_file.sv
// Register file: two asynchronous operand read ports, one asynchronous debug
// read port, one synchronous write port. Register 0 is hardwired to zero.
module alu_issue_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic [ADDR_WIDTH-1:0] raddr_dbg_i,
  output logic [DATA_WIDTH-1:0] rdata_dbg_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents clear on reset; writes to register 0 are dropped so it stays 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = (raddr_a_i   == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o   = (raddr_b_i   == '0) ? '0 : mem_q[raddr_b_i];
  assign rdata_dbg_o = (raddr_dbg_i == '0) ? '0 : mem_q[raddr_dbg_i];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue / writeback stage in front of the ALU. Decodes R-type ops,
// reads operands with forwarding from the op currently in EX, holds one op in
// EX for a single cycle, writes the ALU result back and halts on traps.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_funct,
  input  logic [ADDR_WIDTH-1:0] in_rs,
  input  logic [ADDR_WIDTH-1:0] in_rt,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [2:0]            ALUop,
  output logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] Result,
  input  logic                  Overflow,
  output logic                  halted,
  output logic [1:0]            halt_cause,
  output logic [31:0]           retired,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [1:0]            cause_q, cause_d;
  logic                  ex_valid_q, ex_valid_d;
  logic                  ex_checked_q, ex_checked_d;
  logic [ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]            aluop_q, aluop_d;
  logic [31:0]           retired_q, retired_d;

  logic [DATA_WIDTH-1:0] rf_a, rf_b, opnd_a, opnd_b;
  logic                  trap, accept, wb_en;
  decode_t               dec;

  // The op in EX traps only when it is overflow-checked and the ALU flags it
  assign trap     = ex_valid_q && ex_checked_q && Overflow;
  assign in_ready = (state_q == ST_RUN) && !trap;
  assign accept   = in_valid && in_ready;
  assign wb_en    = ex_valid_q && !trap;
  assign dec      = decode_funct(in_funct);

  alu_issue_reg_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .raddr_a_i  (in_rs),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (in_rt),
    .rdata_b_o  (rf_b),
    .raddr_dbg_i(dbg_addr),
    .rdata_dbg_o(dbg_data),
    .we_i       (wb_en),
    .waddr_i    (ex_rd_q),
    .wdata_i    (Result)
  );

  // Forward the EX result over the file read: the file is only written at
  // the same edge the dependent op is captured, so its value would be stale
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (ex_valid_q && (ex_rd_q != '0) && (ex_rd_q == in_rs)) opnd_a = Result;
    if (ex_valid_q && (ex_rd_q != '0) && (ex_rd_q == in_rt)) opnd_b = Result;
  end

  // Next-state: trap beats illegal (accept is already blocked on a trap)
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    ex_valid_d   = 1'b0;
    ex_checked_d = ex_checked_q;
    ex_rd_d      = ex_rd_q;
    a_d          = a_q;
    b_d          = b_q;
    aluop_d      = aluop_q;
    retired_d    = wb_en ? retired_q + 32'd1 : retired_q;
    if (trap) begin
      state_d = ST_HALT;
      cause_d = HALT_OVF;
    end else if (accept && !dec.legal) begin
      state_d = ST_HALT;
      cause_d = HALT_ILLEGAL;
    end else if (accept) begin
      ex_valid_d   = 1'b1;
      ex_checked_d = dec.checked;
      ex_rd_d      = in_rd;
      a_d          = opnd_a;
      b_d          = opnd_b;
      aluop_d      = dec.aluop;
    end
  end

  // State registers; reset discards any in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cause_q      <= HALT_NONE;
      ex_valid_q   <= 1'b0;
      ex_checked_q <= 1'b0;
      ex_rd_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      aluop_q      <= '0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      ex_valid_q   <= ex_valid_d;
      ex_checked_q <= ex_checked_d;
      ex_rd_q      <= ex_rd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      aluop_q      <= aluop_d;
      retired_q    <= retired_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign ALUop      = aluop_q;
  assign ex_valid   = ex_valid_q;
  assign halted     = (state_q == ST_HALT);
  assign halt_cause = cause_q;
  assign retired    = retired_q;

endmodule
